// File: rtl/vio_step_ctrl_if.sv
// VIO step/reset bundle: host-side step/reset/stimulus and readback, plus the
// model-side clock enable, synchronous reset and data path.
interface vio_step_ctrl_if #(
   parameter int WIDTH     = 25,
   parameter int CNT_WIDTH = 32
);
   logic                        go_vio;
   logic                        rst_vio;
   logic signed [WIDTH-1:0]     v_in_vio;
   logic signed [WIDTH-1:0]     v_out_emu;
   logic                        emu_ce;
   logic                        model_rst;
   logic signed [WIDTH-1:0]     v_in_emu;
   logic signed [WIDTH-1:0]     v_out_vio;
   logic        [CNT_WIDTH-1:0] step_count;
   logic                        busy;
   logic                        overrun;

   modport master (
      output go_vio, rst_vio, v_in_vio, v_out_emu,
      input  emu_ce, model_rst, v_in_emu, v_out_vio, step_count, busy, overrun
   );

   modport slave (
      input  go_vio, rst_vio, v_in_vio, v_out_emu,
      output emu_ce, model_rst, v_in_emu, v_out_vio, step_count, busy, overrun
   );
endinterface

// File: rtl/vio_step_ctrl.sv
// Emulator-side VIO step endpoint: each synchronized go edge yields one bounded
// burst of model clock enables, then the model output is captured for readback.
module vio_step_ctrl #(
   parameter int WIDTH       = 25,
   parameter int STEP_CYCLES = 1,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 32
) (
   input  logic           emu_clk,
   input  logic           emu_rst_n,
   vio_step_ctrl_if.slave bus
);
   localparam int SW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
   localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP    = 2'd1,
      SETTLE  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  go_sync_q, go_sync_d;
   logic [SYNC_STAGES-1:0]  rst_sync_q, rst_sync_d;
   logic [SYNC_STAGES-1:0]  fill_q, fill_d;
   logic                    go_prev_q, go_prev_d;
   logic                    rst_prev_q, rst_prev_d;
   logic [SW-1:0]           cnt_q, cnt_d;
   logic signed [WIDTH-1:0] v_in_emu_q, v_in_emu_d;
   logic signed [WIDTH-1:0] v_out_vio_q, v_out_vio_d;
   logic [CNT_WIDTH-1:0]    step_count_q, step_count_d;
   logic                    emu_ce_q, emu_ce_d;
   logic                    model_rst_q, model_rst_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;

   logic go_s;
   logic rst_s;
   logic fill_done;
   logic go_edge;
   logic rst_rise;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_head
            assign go_sync_d[gi]  = bus.go_vio;
            assign rst_sync_d[gi] = bus.rst_vio;
            assign fill_d[gi]     = 1'b1;
         end else begin : g_tail
            assign go_sync_d[gi]  = go_sync_q[gi-1];
            assign rst_sync_d[gi] = rst_sync_q[gi-1];
            assign fill_d[gi]     = fill_q[gi-1];
         end
      end
   endgenerate

   assign go_s      = go_sync_q[SYNC_STAGES-1];
   assign rst_s     = rst_sync_q[SYNC_STAGES-1];
   assign fill_done = fill_q[SYNC_STAGES-1];
   assign go_edge   = go_s & ~go_prev_q;
   assign rst_rise  = rst_s & ~rst_prev_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      v_in_emu_d   = v_in_emu_q;
      v_out_vio_d  = v_out_vio_q;
      step_count_d = step_count_q;
      overrun_d    = overrun_q;
      rst_prev_d   = rst_s;
      // Until the go chain holds real samples, keep go_prev high so a go_vio
      // already high at reset release never looks like a fresh edge.
      go_prev_d    = fill_done ? go_s : 1'b1;

      case (state_q)
         IDLE: begin
            if (go_edge && !rst_rise) begin
               v_in_emu_d = bus.v_in_vio;
               cnt_d      = STEP_LOAD;
               state_d    = STEP;
            end
         end
         STEP: begin
            if (cnt_q <= SW'(1)) begin
               state_d = SETTLE;
            end else begin
               cnt_d = cnt_q - SW'(1);
            end
         end
         SETTLE: begin
            // The capture register loads as the FSM enters CAPTURE.
            state_d     = CAPTURE;
            v_out_vio_d = bus.v_out_emu;
            if (!rst_s) begin
               step_count_d = step_count_q + CNT_WIDTH'(1);
            end
         end
         CAPTURE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_q != IDLE && go_edge) begin
         overrun_d = 1'b1;
      end

      if (rst_rise && state_q != IDLE) begin
         state_d     = IDLE;
         v_out_vio_d = v_out_vio_q;
      end

      if (rst_s) begin
         step_count_d = '0;
         overrun_d    = 1'b0;
      end

      emu_ce_d    = (state_d == STEP);
      busy_d      = (state_d != IDLE);
      model_rst_d = rst_s;
   end

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         state_q      <= IDLE;
         go_sync_q    <= '0;
         rst_sync_q   <= '1;
         fill_q       <= '0;
         go_prev_q    <= 1'b1;
         rst_prev_q   <= 1'b1;
         cnt_q        <= '0;
         v_in_emu_q   <= '0;
         v_out_vio_q  <= '0;
         step_count_q <= '0;
         emu_ce_q     <= 1'b0;
         model_rst_q  <= 1'b1;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         go_sync_q    <= go_sync_d;
         rst_sync_q   <= rst_sync_d;
         fill_q       <= fill_d;
         go_prev_q    <= go_prev_d;
         rst_prev_q   <= rst_prev_d;
         cnt_q        <= cnt_d;
         v_in_emu_q   <= v_in_emu_d;
         v_out_vio_q  <= v_out_vio_d;
         step_count_q <= step_count_d;
         emu_ce_q     <= emu_ce_d;
         model_rst_q  <= model_rst_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.emu_ce     = emu_ce_q;
   assign bus.model_rst  = model_rst_q;
   assign bus.v_in_emu   = v_in_emu_q;
   assign bus.v_out_vio  = v_out_vio_q;
   assign bus.step_count = step_count_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;

   a_ce_implies_busy : assert property (@(posedge emu_clk) disable iff (!emu_rst_n)
      emu_ce_q |-> busy_q);

   // model_rst high means rst_s was high on the previous edge, which clears both.
   a_rst_clears_status : assert property (@(posedge emu_clk) disable iff (!emu_rst_n)
      model_rst_q |-> (step_count_q == '0 && !overrun_q));
endmodule

// File: tb/tb_vio_step_ctrl.sv
// Randomized bench for vio_step_ctrl: per-window traces of emu_ce/busy/model_rst
// are compared against masks derived from the step timing rules.
module tb_vio_step_ctrl;
   localparam int W  = 25;
   localparam int SC = 3;
   localparam int SS = 2;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   vio_step_ctrl_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

   vio_step_ctrl #(
      .WIDTH(W), .STEP_CYCLES(SC), .SYNC_STAGES(SS), .CNT_WIDTH(CW)
   ) dut (
      .emu_clk   (clk),
      .emu_rst_n (rst_n),
      .bus       (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, advanced once per transaction.
   int                  exp_cnt;
   logic signed [W-1:0] exp_vout;
   logic                exp_ovr;

   // Traces of the latest window: bit c is the value during cycle c.
   logic [127:0] ce_m, busy_m, mrst_m;
   int           vin_bad;
   int           cnt_upd;

   function automatic logic [127:0] span(input int lo, input int hi);
      logic [127:0] m;
      m = '0;
      for (int i = lo; i < hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; bit c of each pattern is the value sampled at edge c.
   task automatic run_window(input logic [127:0] go_pat, input logic [127:0] rst_pat,
                             input int ncyc, input logic signed [W-1:0] vin_exp);
      logic [CW-1:0] cnt0;
      cnt0    = bus.step_count;
      ce_m    = '0;
      busy_m  = '0;
      mrst_m  = '0;
      vin_bad = 0;
      cnt_upd = -1;
      for (int c = 0; c < ncyc; c++) begin
         bus.go_vio  = go_pat[c];
         bus.rst_vio = rst_pat[c];
         @(posedge clk);
         @(negedge clk);
         ce_m[c]   = bus.emu_ce;
         busy_m[c] = bus.busy;
         mrst_m[c] = bus.model_rst;
         if (bus.emu_ce && bus.v_in_emu !== vin_exp) vin_bad++;
         if (cnt_upd < 0 && bus.step_count !== cnt0) cnt_upd = c;
      end
   endtask

   task automatic go_step(input logic signed [W-1:0] vin, input logic signed [W-1:0] vout,
                          input int hl, input logic rst_lvl, input string tag, input bit verbose);
      int ncyc;
      ncyc = ((hl > SS + SC + 3) ? hl : SS + SC + 3) + 2;
      bus.v_in_vio  = vin;
      bus.v_out_emu = vout;
      run_window(span(0, hl), rst_lvl ? span(0, ncyc) : 128'd0, ncyc, vin);
      exp_vout = vout;
      if (rst_lvl) begin
         exp_cnt = 0;
         exp_ovr = 1'b0;
      end else begin
         exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      chk({tag, ".ce"},   ce_m,   span(SS, SS + SC));
      chk({tag, ".busy"}, busy_m, span(SS, SS + SC + 2));
      chk({tag, ".vin"},  128'(vin_bad), 128'd0);
      chk({tag, ".vout"}, bus.v_out_vio, exp_vout);
      chk({tag, ".cnt"},  128'(bus.step_count), 128'(exp_cnt));
      if (!rst_lvl) chk({tag, ".cnt_time"}, 128'(cnt_upd), 128'(SS + SC + 1));
      chk({tag, ".ovr"},  128'(bus.overrun), 128'(exp_ovr));
      if (verbose)
         $display("txn %-10s vin=%h vout=%h hold=%0d rst=%0b count=%0d",
                  tag, vin, vout, hl, rst_lvl, bus.step_count);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic signed [W-1:0] vin, vout;
      rst_n         = 1'b0;
      bus.go_vio    = 1'b0;
      bus.rst_vio   = 1'b1;
      bus.v_in_vio  = '0;
      bus.v_out_emu = '0;
      exp_cnt       = 0;
      exp_vout      = '0;
      exp_ovr       = 1'b0;

      // Reset with random inputs toggling.
      repeat (5) begin
         @(negedge clk);
         bus.go_vio    = 1'($urandom);
         bus.rst_vio   = 1'($urandom);
         bus.v_in_vio  = W'($urandom);
         bus.v_out_emu = W'($urandom);
      end
      @(negedge clk);
      chk("rst.ce",   128'(bus.emu_ce), 128'd0);
      chk("rst.mrst", 128'(bus.model_rst), 128'd1);
      chk("rst.vin",  bus.v_in_emu, 128'd0);
      chk("rst.vout", bus.v_out_vio, 128'd0);
      chk("rst.cnt",  128'(bus.step_count), 128'd0);
      chk("rst.busy", 128'(bus.busy), 128'd0);
      chk("rst.ovr",  128'(bus.overrun), 128'd0);
      $display("txn reset      outputs held at reset values");

      // Release with go already high: no step may start.
      bus.go_vio  = 1'b1;
      bus.rst_vio = 1'b0;
      rst_n       = 1'b1;
      run_window(span(0, 20), 128'd0, 20, '0);
      chk("rel.ce",   ce_m, 128'd0);
      chk("rel.busy", busy_m, 128'd0);
      chk("rel.mrst", mrst_m, span(0, SS));
      chk("rel.cnt",  128'(bus.step_count), 128'd0);
      $display("txn release    go held high through reset release");
      run_window(128'd0, 128'd0, 4, '0);

      go_step(25'h100000, 25'h0ABCDE, 10, 1'b0, "single", 1'b1);
      chk("single.vin_hold", bus.v_in_emu, 128'(25'sh100000));

      go_step(W'($urandom), W'($urandom), 100, 1'b0, "held", 1'b1);

      for (int i = 0; i < 20; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         if (gap > 0) run_window(128'd0, 128'd0, gap, '0);
         go_step(W'($urandom), W'($urandom), $urandom_range(1, 12), 1'b0, "rand", 1'b1);
      end

      // Second edge lands inside the first step: dropped, overrun sticks.
      vin  = W'($urandom);
      vout = W'($urandom);
      bus.v_in_vio  = vin;
      bus.v_out_emu = vout;
      run_window(128'b101, 128'd0, 12, vin);
      exp_cnt  = (exp_cnt + 1) % (1 << CW);
      exp_vout = vout;
      exp_ovr  = 1'b1;
      chk("ovr.ce",   ce_m, span(SS, SS + SC));
      chk("ovr.busy", busy_m, span(SS, SS + SC + 2));
      chk("ovr.cnt",  128'(bus.step_count), 128'(exp_cnt));
      chk("ovr.vout", bus.v_out_vio, exp_vout);
      chk("ovr.flag", 128'(bus.overrun), 128'(exp_ovr));
      $display("txn overrun    second edge 2 cycles after first, count=%0d", bus.step_count);

      go_step(W'($urandom), W'($urandom), 4, 1'b0, "post_ovr", 1'b1);

      // Two edges exactly one minimum go period apart: both accepted.
      vin = W'($urandom);
      vout = W'($urandom);
      bus.v_in_vio  = vin;
      bus.v_out_emu = vout;
      run_window(span(0, 2) | span(8, 10), 128'd0, 18, vin);
      exp_cnt  = (exp_cnt + 2) % (1 << CW);
      exp_vout = vout;
      chk("period.ce",   ce_m, span(SS, SS + SC) | span(8 + SS, 8 + SS + SC));
      chk("period.busy", busy_m, span(SS, SS + SC + 2) | span(8 + SS, 8 + SS + SC + 2));
      chk("period.cnt",  128'(bus.step_count), 128'(exp_cnt));
      chk("period.ovr",  128'(bus.overrun), 128'(exp_ovr));
      $display("txn period     edges 8 cycles apart, count=%0d", bus.step_count);

      // rst_vio sampled from edge 2 aborts the step after its second enable cycle.
      vin = W'($urandom);
      vout = ~exp_vout;
      bus.v_in_vio  = vin;
      bus.v_out_emu = vout;
      run_window(span(0, 4), span(2, 12), 12, vin);
      exp_cnt = 0;
      exp_ovr = 1'b0;
      chk("abort.ce",   ce_m, span(SS, 2 + SS));
      chk("abort.busy", busy_m, span(SS, 2 + SS));
      chk("abort.mrst", mrst_m, span(2 + SS, 12));
      chk("abort.vin",  128'(vin_bad), 128'd0);
      chk("abort.vout", bus.v_out_vio, exp_vout);
      chk("abort.cnt",  128'(bus.step_count), 128'd0);
      chk("abort.ovr",  128'(bus.overrun), 128'd0);
      $display("txn abort      rst during step, vout kept=%h", bus.v_out_vio);

      go_step(W'($urandom), W'($urandom), 4, 1'b1, "rst_step", 1'b1);
      chk("rst_step.mrst", mrst_m, span(0, SS + SC + 5));

      run_window(128'd0, 128'd0, 8, '0);
      chk("unrst.mrst", mrst_m, span(0, SS));
      $display("txn unreset    model_rst released");

      // Go edge and rst rise arrive together: reset wins.
      run_window(span(0, 4), span(0, 10), 10, '0);
      chk("simul.ce",   ce_m, 128'd0);
      chk("simul.busy", busy_m, 128'd0);
      chk("simul.cnt",  128'(bus.step_count), 128'd0);
      $display("txn simul      go and rst together, no step");
      run_window(128'd0, 128'd0, 6, '0);
      exp_cnt = 0;

      for (int i = 0; i < (1 << CW); i++)
         go_step(W'($urandom), W'($urandom), 2, 1'b0, "wrap", 1'b0);
      chk("wrap.zero", 128'(bus.step_count), 128'd0);
      $display("txn wrap       %0d steps, count=%0d", 1 << CW, bus.step_count);
      go_step(W'($urandom), W'($urandom), 2, 1'b0, "wrap_one", 1'b1);
      chk("wrap.one", 128'(bus.step_count), 128'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
